sd_read_sequencer: RTL
======================

# sd_read_sequencer

Controller that sequences one `sd_file_reader` instance: it holds the reader in a local reset, releases it on a start request, and supervises progress through `fatstate`. It applies a no-progress watchdog with bounded automatic retries, and gates and counts the file bytes forwarded to the UART TX path. It sits between `top`-level control (button, host command) and `sd_file_reader`, replacing the direct board-reset-only restart.

## Interface
Parameters:
- `HOLD_CYCLES`, 16: cycles the reader's local reset is held low per attempt (≥1).
- `TIMEOUT_CYCLES`, 50_000_000: no-progress cycles before an attempt is declared hung (1 s at 50 MHz, ≥2).
- `MAX_RETRY`, 3: extra attempts after the first (0..15).
- `DONE_STATE`, 3'd6: reader `fatstate` value meaning the read finished.

Ports:
- `clk` in 1: system clock. One clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle request to begin a read; ignored unless `busy`=0.
- `abort` in 1: single-cycle request to stop the current read and return to IDLE.
- `rd_rst_n` out 1: local active-low reset to `sd_file_reader`.
- `rd_fatstate` in 3: reader `fatstate`.
- `rd_file_found` in 1: reader `file_found`.
- `rd_outreq` in 1: reader byte strobe.
- `rd_outbyte` in 8: reader byte.
- `fwd_req` out 1: forwarded byte strobe, to `uart_tx.wreq`.
- `fwd_data` out 8: forwarded byte.
- `busy` out 1: high from start accept until terminal state.
- `status` out 2: 0=OK, 1=NOT_FOUND, 2=TIMEOUT, 3=ABORTED; valid when `busy`=0 and `done`=1.
- `done` out 1: sticky; set on any terminal state, cleared on next start accept.
- `retries` out 4: attempts used beyond the first in the current or last read.
- `byte_count` out 32: bytes forwarded in the current or last attempt.

## Operation
- FSM states: IDLE, HOLD, RUN, FINISH.
- IDLE: `rd_rst_n`=0. On `start`: clear `done`, `retries`, `byte_count`, and load the hold counter. Go to HOLD.
- HOLD: `rd_rst_n`=0 for exactly HOLD_CYCLES cycles. Then go to RUN and load the watchdog with TIMEOUT_CYCLES.
- RUN: `rd_rst_n`=1.
  - Progress is defined as `rd_outreq`=1 or `rd_fatstate` differing from its previous-cycle value. Progress reloads the watchdog; otherwise the watchdog decrements.
  - `rd_outreq` forwards `rd_outbyte` and increments `byte_count`. The count saturates at 2^32-1.
  - When `rd_fatstate`==DONE_STATE: `status`=OK if `rd_file_found` else NOT_FOUND. Go to FINISH.
  - When the watchdog reaches 0: if `retries`<MAX_RETRY, increment `retries`, clear `byte_count`, and go to HOLD. Otherwise `status`=TIMEOUT and go to FINISH.
- FINISH: set `done`=1 and go to IDLE the next cycle. `rd_rst_n` returns to 0 in IDLE.
- `abort` in HOLD or RUN: `status`=ABORTED, go to FINISH. `abort` in IDLE or FINISH is ignored.
- Simultaneous events in RUN are resolved by priority: `abort` > DONE detection > watchdog expiry. A byte strobe in the same cycle as DONE or abort is still forwarded and counted.
- `start` while `busy`=1 is ignored; no queuing.

## Timing
- Reset values: `rd_rst_n`=0, `fwd_req`=0, `fwd_data`=0, `busy`=0, `done`=0, `status`=0, `retries`=0, `byte_count`=0. FSM=IDLE.
- `fwd_req`/`fwd_data` are registered: one-cycle latency from `rd_outreq`/`rd_outbyte`. `fwd_req` is never asserted outside RUN except for that one-cycle tail.
- `busy` rises the cycle after `start` is sampled and falls the cycle after FINISH.
- `rd_rst_n` is registered and rises exactly HOLD_CYCLES+1 cycles after the `start` sample edge.
- Watchdog reload value TIMEOUT_CYCLES: with no progress, expiry occurs exactly TIMEOUT_CYCLES cycles after RUN entry.
- The previous-`fatstate` register is loaded on RUN entry, so the reset-release transition does not count as spurious progress.
- Asynchronous `rst_n` mid-read forces all outputs to their reset values immediately. The reader is thereby reset too.

## Structure
- Package `sd_seq_pkg`: `seq_state_t` enum, `seq_status_t` enum (OK, NOT_FOUND, TIMEOUT, ABORTED), and the default constant for DONE_STATE.
- One natural sub-module: `sd_seq_watchdog`, a loadable down-counter with reload-on-progress and an expiry flag.
- `top` instantiates `sd_read_sequencer` between `sd_file_reader` and `uart_tx`. The reader's `rst_n` input is driven by `rd_rst_n`.

## Test plan
- Normal read: start; reader model steps `fatstate` 0→6 with `file_found`=1 and emits 5 bytes → 5 `fwd_req` pulses with matching data, `byte_count`=5, `status`=0, `done`=1, `retries`=0.
- File missing: model reaches `fatstate`=6 with `file_found`=0 → `status`=1, `byte_count`=0, `done`=1.
- Hang then success: TIMEOUT_CYCLES=100, MAX_RETRY=2. Model freezes on attempt 1 and succeeds on attempt 2 → `rd_rst_n` low again for 16 cycles, final `retries`=1, `status`=0.
- Permanent hang: MAX_RETRY=2, model never progresses → 3 attempts, `retries`=2, `status`=2, `busy` falls 3×(16+100)+small fixed overhead cycles after start.
- Abort during byte stream: 3 bytes sent, `abort` coincident with the 4th `rd_outreq` → 4 bytes forwarded, `status`=3, `rd_rst_n`=0 in IDLE. A `start` issued while `busy`=1 is ignored.
- Async reset mid-RUN: `rst_n` low between clock edges → all outputs at reset values before the next edge; a new start after release runs normally.

Source files
------------

// File: rtl/sd_seq_pkg.sv
// -----------------------------------------------------------------------------
// sd_seq_pkg
// Shared types and constants for the SD read sequencer.
//   seq_state_t        : sequencer FSM states
//   seq_status_t       : completion code reported on the status port
//   DONE_STATE_DEFAULT : sd_file_reader fatstate value meaning "read finished"
// -----------------------------------------------------------------------------
package sd_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_NOT_FOUND = 2'd1,
    ST_TIMEOUT   = 2'd2,
    ST_ABORTED   = 2'd3
  } seq_status_t;

  localparam logic [2:0] DONE_STATE_DEFAULT = 3'd6;

endpackage : sd_seq_pkg

// File: rtl/sd_seq_watchdog.sv
// -----------------------------------------------------------------------------
// sd_seq_watchdog
// Loadable no-progress down-counter. Loaded with TIMEOUT_CYCLES on `load`,
// reloaded whenever `progress` is seen while enabled, otherwise decremented
// each enabled cycle. `expired` is a combinational flag that is high in the
// cycle whose closing edge would take the count to zero, so the owner acts on
// exactly the TIMEOUT_CYCLES-th idle cycle after the load.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : force the counter to TIMEOUT_CYCLES
//   en         : counting enable (owner is supervising)
//   progress   : activity seen this cycle; reloads the counter
//   expired    : no-progress limit reached this cycle
// -----------------------------------------------------------------------------
module sd_seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  input  logic progress,
  output logic expired
);

  localparam int unsigned     CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load || (en && progress)) begin
      cnt_q <= RELOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - ONE;
    end
  end

  assign expired = en && !load && !progress && (cnt_q == ONE);

endmodule : sd_seq_watchdog

// File: rtl/sd_read_sequencer.sv
// -----------------------------------------------------------------------------
// sd_read_sequencer
// Sequences one sd_file_reader: holds it in a local reset while idle, releases
// it after a fixed hold on a start request, supervises fatstate for progress
// with a watchdog and bounded retries, and forwards/counts the file bytes.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, abort    : single-cycle control requests
//   rd_rst_n        : local active-low reset to the reader (registered)
//   rd_fatstate     : reader fatstate
//   rd_file_found   : reader file_found
//   rd_outreq/outbyte : reader byte strobe and data
//   fwd_req/fwd_data  : registered forwarded byte to uart_tx
//   busy            : read in progress
//   status          : seq_status_t code, valid when busy=0 and done=1
//   done            : sticky completion flag, cleared on start accept
//   retries         : attempts beyond the first in the current/last read
//   byte_count      : saturating count of bytes forwarded in the last attempt
// -----------------------------------------------------------------------------
module sd_read_sequencer
  import sd_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter logic [2:0]  DONE_STATE     = DONE_STATE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        rd_rst_n,
  input  logic [2:0]  rd_fatstate,
  input  logic        rd_file_found,
  input  logic        rd_outreq,
  input  logic [7:0]  rd_outbyte,
  output logic        fwd_req,
  output logic [7:0]  fwd_data,
  output logic        busy,
  output logic [1:0]  status,
  output logic        done,
  output logic [3:0]  retries,
  output logic [31:0] byte_count
);

  // Hold counter runs HOLD_CYCLES-1 .. 0, so it needs clog2(HOLD_CYCLES) bits.
  localparam int unsigned      HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
  localparam logic [3:0]        RETRY_LIMIT = 4'(MAX_RETRY);

  seq_state_t  state_q, state_d;
  seq_status_t status_q, status_d;

  logic [HOLD_W-1:0] hold_cnt_q;
  logic [2:0]        prev_fat_q;
  logic              rd_rst_n_q;
  logic              fwd_req_q;
  logic [7:0]        fwd_data_q;
  logic              busy_q;
  logic              done_q;
  logic [3:0]        retries_q;
  logic [31:0]       byte_count_q;

  logic in_run;
  logic byte_take;
  logic progress;
  logic wd_expired;
  logic hold_load;
  logic wd_load;
  logic start_take;
  logic retry_take;

  assign in_run    = (state_q == S_RUN);
  assign byte_take = in_run && rd_outreq;
  // Any byte or any fatstate movement counts as the reader being alive.
  assign progress  = rd_outreq || (rd_fatstate != prev_fat_q);

  sd_seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wd_load),
    .en       (in_run),
    .progress (progress),
    .expired  (wd_expired)
  );

  // ---------------------------------------------------------------------------
  // Next-state / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    status_d   = status_q;
    hold_load  = 1'b0;
    wd_load    = 1'b0;
    start_take = 1'b0;
    retry_take = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          start_take = 1'b1;
          hold_load  = 1'b1;
          state_d    = S_HOLD;
        end
      end

      S_HOLD: begin
        if (abort) begin
          status_d = ST_ABORTED;
          state_d  = S_FINISH;
        end else if (hold_cnt_q == '0) begin
          wd_load = 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // Priority: abort > reader done > watchdog expiry.
        if (abort) begin
          status_d = ST_ABORTED;
          state_d  = S_FINISH;
        end else if (rd_fatstate == DONE_STATE) begin
          status_d = rd_file_found ? ST_OK : ST_NOT_FOUND;
          state_d  = S_FINISH;
        end else if (wd_expired) begin
          if (retries_q < RETRY_LIMIT) begin
            retry_take = 1'b1;
            hold_load  = 1'b1;
            state_d    = S_HOLD;
          end else begin
            status_d = ST_TIMEOUT;
            state_d  = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      status_q     <= ST_OK;
      hold_cnt_q   <= '0;
      prev_fat_q   <= '0;
      rd_rst_n_q   <= 1'b0;
      fwd_req_q    <= 1'b0;
      fwd_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      retries_q    <= '0;
      byte_count_q <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      busy_q   <= (state_d != S_IDLE);

      // Released one cycle after RUN entry and dropped one cycle after RUN
      // exit, giving exactly HOLD_CYCLES low cycles between retry attempts.
      rd_rst_n_q <= in_run;

      if (hold_load) begin
        hold_cnt_q <= HOLD_RELOAD;
      end else if ((state_q == S_HOLD) && (hold_cnt_q != '0)) begin
        hold_cnt_q <= hold_cnt_q - HOLD_ONE;
      end

      // Snapshot on RUN entry so the reset-release value is not seen as a
      // fatstate change; track every cycle while running.
      if (wd_load || in_run) begin
        prev_fat_q <= rd_fatstate;
      end

      fwd_req_q <= byte_take;
      if (byte_take) begin
        fwd_data_q <= rd_outbyte;
      end

      if (start_take || retry_take) begin
        byte_count_q <= '0;
      end else if (byte_take && (byte_count_q != '1)) begin
        byte_count_q <= byte_count_q + 32'd1;
      end

      if (start_take) begin
        retries_q <= '0;
      end else if (retry_take) begin
        retries_q <= retries_q + 4'd1;
      end

      if (start_take) begin
        done_q <= 1'b0;
      end else if (state_q == S_FINISH) begin
        done_q <= 1'b1;
      end
    end
  end

  assign rd_rst_n   = rd_rst_n_q;
  assign fwd_req    = fwd_req_q;
  assign fwd_data   = fwd_data_q;
  assign busy       = busy_q;
  assign status     = status_q;
  assign done       = done_q;
  assign retries    = retries_q;
  assign byte_count = byte_count_q;

endmodule : sd_read_sequencer
